// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared FP sizing helpers, FSM encodings and rule codes
//
// Purpose: derives the mantissa and exponent widths from the operand width.
// It also provides the all-ones exponent and the encodings that the
// normalization stage uses.
// Ports: none (package).
package fp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // One normalization decision per SHIFT cycle, listed in priority order.
  typedef enum logic [2:0] {
    ACT_ZERO   = 3'd0,
    ACT_OVF    = 3'd1,
    ACT_CARRY  = 3'd2,
    ACT_NORM   = 3'd3,
    ACT_SUBN   = 3'd4,
    ACT_LSHIFT = 3'd5
  } act_t;

  function automatic int mant_size(input int size);
    return (size == 64) ? 52 : 23;
  endfunction

  function automatic int exp_size(input int size);
    return (size == 64) ? 11 : 8;
  endfunction

  // Exponent value reserved for Inf/NaN.
  function automatic int exp_all_ones(input int size);
    return (1 << exp_size(size)) - 1;
  endfunction

endpackage

// File: rtl/fp_normalize_if.sv
// rtl/fp_normalize_if.sv - handshake and data bundle around the normalization stage
//
// Purpose: groups the upstream (in_*) and downstream (out_*) channels.
// Ports/modports:
//   master - the environment: drives in_valid/in_sign/in_exp/in_mant and out_ready.
//   slave  - the normalizer: drives in_ready and out_valid/out_sign/out_exp/out_mant/flags.
interface fp_normalize_if import fp_pkg::*; #(
  parameter int Size = 64
) ();

  localparam int MantSize = mant_size(Size);
  localparam int ExpSize  = exp_size(Size);

  logic                in_valid;
  logic                in_ready;
  logic                in_sign;
  logic [ExpSize-1:0]  in_exp;
  logic [MantSize+4:0] in_mant;

  logic                out_valid;
  logic                out_ready;
  logic                out_sign;
  logic [ExpSize-1:0]  out_exp;
  logic [MantSize+3:0] out_mant;
  logic                out_overflow;
  logic                out_zero;

  modport master (
    output in_valid, in_sign, in_exp, in_mant, out_ready,
    input  in_ready, out_valid, out_sign, out_exp, out_mant, out_overflow, out_zero
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_mant, out_ready,
    output in_ready, out_valid, out_sign, out_exp, out_mant, out_overflow, out_zero
  );

endinterface

// File: rtl/cla_adder.sv
// rtl/cla_adder.sv - exponent +1 / -1 unit built on a carry-lookahead chain
//
// Purpose: sum = a + 1 when sub=0, sum = a - 1 when sub=1. The result is taken
// modulo 2^InputSize.
// Ports:
//   a   in  InputSize  operand
//   sub in  1          1 = decrement, 0 = increment
//   sum out InputSize  result
module cla_adder #(
  parameter int InputSize = 8
) (
  input  logic [InputSize-1:0] a,
  input  logic                 sub,
  output logic [InputSize-1:0] sum
);

  logic [InputSize-1:0] b;
  logic [InputSize-1:0] carry;

  // Decrement is addition of all-ones; increment is addition of one.
  assign b = sub ? {InputSize{1'b1}} : InputSize'(1);

  always_comb begin
    carry = '0;
    for (int i = 1; i < InputSize; i++) begin
      carry[i] = (a[i-1] & b[i-1]) | ((a[i-1] ^ b[i-1]) & carry[i-1]);
    end
    sum = a ^ b ^ carry;
  end

endmodule

// File: rtl/fp_normalize.sv
// rtl/fp_normalize.sv - iterative post-add normalization stage of the FP adder
//
// Purpose: takes a raw aligned sum {carry, hidden, fraction, G, R, S} and a
// tentative exponent. It returns a normalized {hidden, fraction, G, R, S} and
// the adjusted exponent. A carry-out costs one right shift. Cancellation costs
// one left shift per cycle.
// Ports:
//   clk    in  clock, rising edge
//   reset  in  synchronous, active-high; abandons any operand in flight
//   bus    fp_normalize_if.slave:
//          in_valid/in_ready/in_sign/in_exp/in_mant        upstream channel
//          out_valid/out_ready/out_sign/out_exp/out_mant   downstream channel
//          out_overflow (exponent hit all-ones), out_zero (mantissa is zero)
module fp_normalize import fp_pkg::*; #(
  parameter int Size = 64
) (
  input  logic          clk,
  input  logic          reset,
  fp_normalize_if.slave bus
);

  localparam int MantSize = mant_size(Size);
  localparam int ExpSize  = exp_size(Size);
  localparam int MW       = MantSize + 5;
  localparam logic [ExpSize-1:0] ExpOnes = ExpSize'(exp_all_ones(Size));

  state_t state;
  state_t state_nxt;
  act_t   act;

  logic [MW-1:0]      m;
  logic [ExpSize-1:0] e;
  logic [ExpSize-1:0] e_adj;
  logic               s;
  logic               zero;
  logic               overflow;
  logic               adj_sub;

  // The only increment happens on carry-out. Every other adjustment is a decrement.
  assign adj_sub = ~m[MW-1];

  cla_adder #(.InputSize(ExpSize)) u_exp_adj (
    .a   (e),
    .sub (adj_sub),
    .sum (e_adj)
  );

  always_comb begin
    act = ACT_LSHIFT;
    if (m == '0)
      act = ACT_ZERO;
    else if (e == ExpOnes)
      act = ACT_OVF;
    else if (m[MW-1])
      act = ACT_CARRY;
    else if (m[MW-2])
      act = ACT_NORM;
    else if (e <= ExpSize'(1))
      act = ACT_SUBN;  // hidden bit still clear and no exponent left to spend
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nxt = SHIFT;
      SHIFT:   if (act != ACT_LSHIFT) state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready     = (state == IDLE);
    bus.out_valid    = (state == DONE);
    bus.out_sign     = s;
    bus.out_exp      = e;
    bus.out_mant     = m[MW-2:0];
    bus.out_overflow = overflow;
    bus.out_zero     = zero;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m        <= '0;
      e        <= '0;
      s        <= 1'b0;
      zero     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            m        <= bus.in_mant;
            e        <= bus.in_exp;
            s        <= bus.in_sign;
            zero     <= 1'b0;
            overflow <= 1'b0;
          end
        end
        SHIFT: begin
          case (act)
            ACT_ZERO: begin
              e    <= '0;
              zero <= 1'b1;
            end
            ACT_OVF:  overflow <= 1'b1;
            ACT_CARRY: begin
              // Bit shifted out folds into sticky so rounding still sees it.
              m        <= {1'b0, m[MW-1:2], m[1] | m[0]};
              e        <= e_adj;
              overflow <= (e_adj == ExpOnes);
            end
            ACT_SUBN: e <= '0;
            ACT_LSHIFT: begin
              m <= {m[MW-2:0], 1'b0};
              e <= e_adj;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_normalize.sv
// tb/tb_fp_normalize.sv - randomized self-checking bench for fp_normalize (Size=32)
module tb_fp_normalize;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  fp_normalize_if #(.Size(32)) bus ();

  fp_normalize #(.Size(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  // The reference model works from the leading-one position and the available
  // exponent headroom. It does not step through cycles.
  task automatic ref_model(input logic [27:0] mant, input logic [7:0] exp,
                           output logic [26:0] em, output logic [7:0] ee,
                           output logic ez, output logic eo, output int k);
    int unsigned mv;
    int p, d, ev;
    mv = mant;
    ev = exp;
    ez = 1'b0;
    eo = 1'b0;
    k  = 0;
    if (mv == 0) begin
      em = '0;
      ee = '0;
      ez = 1'b1;
    end else if (ev == 255) begin
      em = 27'(mv);
      ee = 8'hFF;
      eo = 1'b1;
    end else if (mv >= 32'h0800_0000) begin
      em = 27'((mv >> 1) | (mv & 1));
      ee = 8'(ev + 1);
      eo = ((ev + 1) == 255);
    end else begin
      p = 0;
      for (int i = 0; i < 27; i++)
        if (((mv >> i) & 1) != 0) p = i;
      d = 26 - p;
      if (ev > d) begin
        k  = d;
        ee = 8'(ev - d);
      end else begin
        k  = (ev > 0) ? ev - 1 : 0;
        ee = '0;
      end
      em = 27'(mv << k);
    end
  endtask

  task automatic run_op(input logic [27:0] mant, input logic [7:0] exp,
                        input logic sign, input int hold);
    logic [26:0] em;
    logic [7:0]  ee;
    logic        ez, eo;
    int          k, lat;
    ref_model(mant, exp, em, ee, ez, eo, k);
    @(negedge clk);
    check("in_ready_idle", bus.in_ready, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_mant  = mant;
    bus.in_exp   = exp;
    bus.in_sign  = sign;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_mant  = '0;
    bus.in_exp   = '0;
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", 64'(lat), 64'(1 + k));
    check("out_mant", bus.out_mant, em);
    check("out_exp", bus.out_exp, ee);
    check("out_sign", bus.out_sign, sign);
    check("out_zero", bus.out_zero, ez);
    check("out_overflow", bus.out_overflow, eo);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("hold_stable", {bus.out_valid, bus.in_ready, bus.out_zero, bus.out_overflow,
                            bus.out_sign, bus.out_exp, bus.out_mant},
                           {1'b1, 1'b0, ez, eo, sign, ee, em});
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("after_handshake", {bus.out_valid, bus.in_ready}, 2'b01);
  endtask

  initial begin
    logic [27:0] rm, one, mask;
    logic [7:0]  rx;
    int          p, sel;

    bus.in_valid  = 1'b0;
    bus.in_sign   = 1'b0;
    bus.in_exp    = '0;
    bus.in_mant   = '0;
    bus.out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_data", {bus.out_sign, bus.out_exp, bus.out_mant}, '0);
    check("rst_flags", {bus.out_zero, bus.out_overflow}, 2'b00);
    @(negedge clk);
    reset = 1'b0;

    run_op(28'h8000003, 8'h80, 1'b0, 0);
    run_op(28'h4000000, 8'h7F, 1'b1, 0);
    run_op(28'h0800000, 8'h80, 1'b0, 1);
    run_op(28'h0400000, 8'h02, 1'b1, 0);
    run_op(28'h0000000, 8'h90, 1'b0, 0);
    run_op(28'h8000000, 8'hFE, 1'b1, 5);
    run_op(28'h0000001, 8'h80, 1'b0, 2);
    run_op(28'h4000000, 8'h00, 1'b0, 0);
    run_op(28'h8000000, 8'hFF, 1'b1, 0);

    // Reset while the stage is still left-shifting.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_mant  = 28'h0000001;
    bus.in_exp   = 8'h80;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_out_valid", bus.out_valid, 1'b0);
    check("mid_rst_in_ready", bus.in_ready, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("mid_rst_abandoned", bus.out_valid, 1'b0);

    one = 28'h1;
    for (int n = 0; n < 300; n++) begin
      p = $urandom_range(0, 28);
      if (p == 28) begin
        rm = '0;
      end else begin
        mask = (one << p) - one;
        rm   = (one << p) | (28'($urandom) & mask);
      end
      sel = $urandom_range(0, 7);
      case (sel)
        0:       rx = 8'h00;
        1:       rx = 8'h01;
        2:       rx = 8'h02;
        3:       rx = 8'hFE;
        4:       rx = 8'hFF;
        5:       rx = 8'($urandom_range(0, 30));
        default: rx = 8'($urandom_range(0, 255));
      endcase
      run_op(rm, rx, 1'($urandom), $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
